// File: rtl/cuenta_regresiva_rtc.sv
// -----------------------------------------------------------------------------
// cuenta_regresiva_rtc
// Countdown timer holding hh:mm:ss in packed BCD (one byte per field). Each
// effective tick subtracts one second with full BCD borrow propagation. The
// block supports loading with per-field clamping, pausing, zero detection and
// either stop-at-zero or continuous wrap-around operation.
//
// Parameters:
//   HORA_MAX      highest BCD hour value; hours wrap to it and loads clamp to it
//   MODO_CONTINUO 0 = stop at 00:00:00, 1 = wrap to HORA_MAX:59:59 and continue
//   DIV_TICK      0 = use the tick input, N>0 = internal tick every N RUN cycles
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   cargar       load strobe for hora_in/minuto_in/segundo_in
//   hora_in      BCD hours to load
//   minuto_in    BCD minutes to load
//   segundo_in   BCD seconds to load
//   habilitar    level enable: 1 = count, 0 = pause
//   tick         one-cycle 1 Hz strobe (only used when DIV_TICK = 0)
//   hora_out     registered BCD hours
//   minuto_out   registered BCD minutes
//   segundo_out  registered BCD seconds
//   activo       high while counting (state RUN)
//   fin          one-cycle pulse when a tick brings the count to 00:00:00
// -----------------------------------------------------------------------------
module cuenta_regresiva_rtc #(
   parameter logic [7:0] HORA_MAX      = 8'h23,
   parameter bit         MODO_CONTINUO = 1'b0,
   parameter int         DIV_TICK      = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cargar,
   input  logic [7:0] hora_in,
   input  logic [7:0] minuto_in,
   input  logic [7:0] segundo_in,
   input  logic       habilitar,
   input  logic       tick,
   output logic [7:0] hora_out,
   output logic [7:0] minuto_out,
   output logic [7:0] segundo_out,
   output logic       activo,
   output logic       fin
);

   localparam int PRESC_W = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
   localparam logic [PRESC_W-1:0] PRESC_FIN = (DIV_TICK > 1) ? PRESC_W'(DIV_TICK - 1) : '0;
   localparam logic [7:0] MAX_MIN_SEG = 8'h59;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } estado_t;

   estado_t              estado_q;
   logic [7:0]           hora_q;
   logic [7:0]           minuto_q;
   logic [7:0]           segundo_q;
   logic                 fin_q;
   logic [PRESC_W-1:0]   prescaler_q;

   logic [7:0]           horaDec_d;
   logic [7:0]           minutoDec_d;
   logic [7:0]           segundoDec_d;
   logic                 prestamoSeg;
   logic                 prestamoMin;
   logic                 valorCero;
   logic                 decCero;
   logic                 tickEfectivo;

   // A loaded field is replaced by its maximum when either nibble is not a
   // decimal digit or when the whole value is above the maximum. For valid
   // BCD, comparing the bytes as binary gives the same order as decimal.
   function automatic logic [7:0] limitarBcd(input logic [7:0] valor,
                                             input logic [7:0] maximo);
      if ((valor[7:4] > 4'd9) || (valor[3:0] > 4'd9) || (valor > maximo)) begin
         return maximo;
      end
      return valor;
   endfunction

   // Next value after one second is subtracted, computed purely in BCD.
   // Seconds borrow from minutes when they are 00, minutes borrow from hours
   // when they are 00 and a borrow arrives, and hours only wrap to HORA_MAX
   // from 00:00:00, which the FSM allows only in continuous mode.
   always_comb begin
      segundoDec_d = segundo_q;
      minutoDec_d  = minuto_q;
      horaDec_d    = hora_q;
      prestamoSeg  = 1'b0;
      prestamoMin  = 1'b0;

      if (segundo_q == 8'h00) begin
         segundoDec_d = MAX_MIN_SEG;
         prestamoSeg  = 1'b1;
      end else if (segundo_q[3:0] == 4'h0) begin
         segundoDec_d = {segundo_q[7:4] - 4'h1, 4'h9};
      end else begin
         segundoDec_d = {segundo_q[7:4], segundo_q[3:0] - 4'h1};
      end

      if (prestamoSeg) begin
         if (minuto_q == 8'h00) begin
            minutoDec_d = MAX_MIN_SEG;
            prestamoMin = 1'b1;
         end else if (minuto_q[3:0] == 4'h0) begin
            minutoDec_d = {minuto_q[7:4] - 4'h1, 4'h9};
         end else begin
            minutoDec_d = {minuto_q[7:4], minuto_q[3:0] - 4'h1};
         end
      end

      if (prestamoMin) begin
         if (hora_q == 8'h00) begin
            horaDec_d = HORA_MAX;
         end else if (hora_q[3:0] == 4'h0) begin
            horaDec_d = {hora_q[7:4] - 4'h1, 4'h9};
         end else begin
            horaDec_d = {hora_q[7:4], hora_q[3:0] - 4'h1};
         end
      end
   end

   // Zero detection on the present value (gates IDLE->RUN) and on the
   // decremented value (raises fin and ends the count in stop mode).
   assign valorCero = (hora_q == 8'h00) && (minuto_q == 8'h00) && (segundo_q == 8'h00);
   assign decCero   = (horaDec_d == 8'h00) && (minutoDec_d == 8'h00) && (segundoDec_d == 8'h00);

   // With the internal prescaler the external tick is ignored entirely; the
   // terminal count is only reached while RUN, since the prescaler is held at
   // zero in every other state.
   assign tickEfectivo = (DIV_TICK == 0) ? tick : (prescaler_q == PRESC_FIN);

   // Single FSM register block. Load beats any tick or state transition and
   // always lands in IDLE, so a load into a running timer costs one cycle of
   // IDLE before counting resumes. fin defaults low every cycle so it can only
   // ever be a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q    <= IDLE;
         hora_q      <= 8'h00;
         minuto_q    <= 8'h00;
         segundo_q   <= 8'h00;
         fin_q       <= 1'b0;
         prescaler_q <= '0;
      end else begin
         fin_q <= 1'b0;
         if (cargar) begin
            hora_q      <= limitarBcd(hora_in, HORA_MAX);
            minuto_q    <= limitarBcd(minuto_in, MAX_MIN_SEG);
            segundo_q   <= limitarBcd(segundo_in, MAX_MIN_SEG);
            prescaler_q <= '0;
            estado_q    <= IDLE;
         end else begin
            case (estado_q)
               IDLE: begin
                  prescaler_q <= '0;
                  if (habilitar && (!valorCero || MODO_CONTINUO)) begin
                     estado_q <= RUN;
                  end
               end
               RUN: begin
                  if (!habilitar) begin
                     prescaler_q <= '0;
                     estado_q    <= IDLE;
                  end else begin
                     if (DIV_TICK > 0) begin
                        if (tickEfectivo) begin
                           prescaler_q <= '0;
                        end else begin
                           prescaler_q <= prescaler_q + 1'b1;
                        end
                     end
                     if (tickEfectivo) begin
                        hora_q    <= horaDec_d;
                        minuto_q  <= minutoDec_d;
                        segundo_q <= segundoDec_d;
                        if (decCero) begin
                           fin_q <= 1'b1;
                           if (!MODO_CONTINUO) begin
                              estado_q <= DONE;
                           end
                        end
                     end
                  end
               end
               DONE: begin
                  prescaler_q <= '0;
                  if (!habilitar) begin
                     estado_q <= IDLE;
                  end
               end
               default: begin
                  prescaler_q <= '0;
                  estado_q    <= IDLE;
               end
            endcase
         end
      end
   end

   assign hora_out    = hora_q;
   assign minuto_out  = minuto_q;
   assign segundo_out = segundo_q;
   assign fin         = fin_q;
   assign activo      = (estado_q == RUN);

endmodule

// File: tb/tb_cuenta_regresiva_rtc.sv
// -----------------------------------------------------------------------------
// tb_cuenta_regresiva_rtc
// Scoreboard bench for cuenta_regresiva_rtc. Three instances share the same
// stimulus: dut0 (stop at zero, external tick), dut1 (continuous mode) and
// dut2 (internal prescaler of 4). Each stimulus cycle pushes the expected
// outputs of one selected instance; a monitor pops and compares them just
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_cuenta_regresiva_rtc;

   typedef struct {
      int          sel;
      logic [25:0] esperado;
      string       tag;
   } entrada_t;

   logic       clk;
   logic       reset;
   logic       cargar;
   logic [7:0] horaIn;
   logic [7:0] minutoIn;
   logic [7:0] segundoIn;
   logic       habilitar;
   logic       tick;

   logic [7:0] hora0, minuto0, segundo0;
   logic       activo0, fin0;
   logic [7:0] hora1, minuto1, segundo1;
   logic       activo1, fin1;
   logic [7:0] hora2, minuto2, segundo2;
   logic       activo2, fin2;

   entrada_t   sb[$];
   entrada_t   actual;
   int         testsRun = 0;
   int         testsFailed = 0;

   cuenta_regresiva_rtc dut0 (
      .clk(clk), .reset(reset), .cargar(cargar),
      .hora_in(horaIn), .minuto_in(minutoIn), .segundo_in(segundoIn),
      .habilitar(habilitar), .tick(tick),
      .hora_out(hora0), .minuto_out(minuto0), .segundo_out(segundo0),
      .activo(activo0), .fin(fin0)
   );

   cuenta_regresiva_rtc #(.MODO_CONTINUO(1'b1)) dut1 (
      .clk(clk), .reset(reset), .cargar(cargar),
      .hora_in(horaIn), .minuto_in(minutoIn), .segundo_in(segundoIn),
      .habilitar(habilitar), .tick(tick),
      .hora_out(hora1), .minuto_out(minuto1), .segundo_out(segundo1),
      .activo(activo1), .fin(fin1)
   );

   cuenta_regresiva_rtc #(.DIV_TICK(4)) dut2 (
      .clk(clk), .reset(reset), .cargar(cargar),
      .hora_in(horaIn), .minuto_in(minutoIn), .segundo_in(segundoIn),
      .habilitar(habilitar), .tick(tick),
      .hora_out(hora2), .minuto_out(minuto2), .segundo_out(segundo2),
      .activo(activo2), .fin(fin2)
   );

   // Free-running 10 time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [25:0] esp(input logic [23:0] valor,
                                       input logic act, input logic f);
      return {valor, act, f};
   endfunction

   function automatic logic [25:0] observado(input int sel);
      case (sel)
         1:       return {hora1, minuto1, segundo1, activo1, fin1};
         2:       return {hora2, minuto2, segundo2, activo2, fin2};
         default: return {hora0, minuto0, segundo0, activo0, fin0};
      endcase
   endfunction

   // The one comparison point: counts every check and reports a mismatch
   // field by field.
   task automatic checkOutput(input string tag, input logic [25:0] obs,
                              input logic [25:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h:%h:%h activo=%b fin=%b, expected %h:%h:%h activo=%b fin=%b",
                  tag, obs[25:18], obs[17:10], obs[9:2], obs[1], obs[0],
                  exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
      end
   endtask

   // Drives one cycle of inputs on the falling edge and queues what the
   // selected instance must show after the next rising edge.
   task automatic applyStimulus(input logic rst, input logic ld,
                                input logic [23:0] valor, input logic hab,
                                input logic tk, input int sel,
                                input logic [25:0] exp, input string tag);
      entrada_t e;
      @(negedge clk);
      reset     = rst;
      cargar    = ld;
      horaIn    = valor[23:16];
      minutoIn  = valor[15:8];
      segundoIn = valor[7:0];
      habilitar = hab;
      tick      = tk;
      e.sel      = sel;
      e.esperado = exp;
      e.tag      = tag;
      sb.push_back(e);
   endtask

   // Monitor: one queued expectation is consumed per rising edge, sampled
   // one time unit after the edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         actual = sb.pop_front();
         checkOutput(actual.tag, observado(actual.sel), actual.esperado);
      end
   end

   initial begin
      reset     = 1'b0;
      cargar    = 1'b0;
      horaIn    = 8'h00;
      minutoIn  = 8'h00;
      segundoIn = 8'h00;
      habilitar = 1'b0;
      tick      = 1'b0;

      // Reset and single-tick borrow cases on the stop-at-zero instance.
      applyStimulus(1, 0, 24'h000000, 0, 0, 0, esp(24'h000000, 0, 0), "reset");
      applyStimulus(0, 1, 24'h000100, 1, 0, 0, esp(24'h000100, 0, 0), "A_load");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h000100, 1, 0), "A_run");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h000059, 1, 0), "A_tick");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h000059, 1, 0), "A_hold");
      applyStimulus(0, 1, 24'h010000, 1, 0, 0, esp(24'h010000, 0, 0), "B_load");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h010000, 1, 0), "B_run");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h005959, 1, 0), "B_tick");
      applyStimulus(0, 1, 24'h000010, 1, 0, 0, esp(24'h000010, 0, 0), "C_load");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h000010, 1, 0), "C_run");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h000009, 1, 0), "C_tick");

      // Count down to zero and stop in DONE.
      applyStimulus(0, 1, 24'h000002, 1, 0, 0, esp(24'h000002, 0, 0), "D_load");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h000002, 1, 0), "D_run");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h000001, 1, 0), "D_tick1");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h000001, 1, 0), "D_hold");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h000000, 0, 1), "D_zero");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h000000, 0, 0), "D_finEnd");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h000000, 0, 0), "D_done");
      applyStimulus(0, 0, 24'h000000, 0, 0, 0, esp(24'h000000, 0, 0), "D_release");

      // Loading zero with habilitar high must neither start nor pulse fin.
      applyStimulus(0, 1, 24'h000000, 1, 0, 0, esp(24'h000000, 0, 0), "E_loadZero");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h000000, 0, 0), "E_idleZero");

      // Clamping, load-versus-tick priority and pause.
      applyStimulus(0, 1, 24'h2A7B61, 0, 0, 0, esp(24'h235959, 0, 0), "F_clampNib");
      applyStimulus(0, 0, 24'h000000, 1, 0, 0, esp(24'h235959, 1, 0), "F_run");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h235958, 1, 0), "F_tick");
      applyStimulus(0, 1, 24'h000005, 1, 1, 0, esp(24'h000005, 0, 0), "F_loadTick");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h000005, 1, 0), "F_idleTick");
      applyStimulus(0, 0, 24'h000000, 1, 1, 0, esp(24'h000004, 1, 0), "F_tick2");
      applyStimulus(0, 0, 24'h000000, 0, 1, 0, esp(24'h000004, 0, 0), "F_pause");
      applyStimulus(0, 0, 24'h000000, 0, 1, 0, esp(24'h000004, 0, 0), "F_paused");
      applyStimulus(0, 1, 24'h246030, 0, 0, 0, esp(24'h235930, 0, 0), "F_clampMax");

      // Continuous mode: fin at zero, then wrap to HORA_MAX:59:59.
      applyStimulus(1, 0, 24'h000000, 0, 0, 1, esp(24'h000000, 0, 0), "G_reset");
      applyStimulus(0, 1, 24'h000001, 1, 0, 1, esp(24'h000001, 0, 0), "G_load");
      applyStimulus(0, 0, 24'h000000, 1, 0, 1, esp(24'h000001, 1, 0), "G_run");
      applyStimulus(0, 0, 24'h000000, 1, 1, 1, esp(24'h000000, 1, 1), "G_zero");
      applyStimulus(0, 0, 24'h000000, 1, 1, 1, esp(24'h235959, 1, 0), "G_wrap");
      applyStimulus(0, 0, 24'h000000, 1, 0, 1, esp(24'h235959, 1, 0), "G_hold");
      applyStimulus(0, 1, 24'h000000, 1, 0, 1, esp(24'h000000, 0, 0), "G_loadZero");
      applyStimulus(0, 0, 24'h000000, 1, 0, 1, esp(24'h000000, 1, 0), "G_runZero");
      applyStimulus(0, 0, 24'h000000, 1, 1, 1, esp(24'h235959, 1, 0), "G_wrapZero");

      // Internal prescaler of 4 with the tick input held high (ignored),
      // then a reset in the middle of the run.
      applyStimulus(1, 0, 24'h000000, 0, 1, 2, esp(24'h000000, 0, 0), "H_reset");
      applyStimulus(0, 1, 24'h000003, 1, 1, 2, esp(24'h000003, 0, 0), "H_load");
      applyStimulus(0, 0, 24'h000000, 1, 1, 2, esp(24'h000003, 1, 0), "H_run");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 24'h000000, 1, 1, 2, esp(24'h000003, 1, 0), "H_wait1");
      end
      applyStimulus(0, 0, 24'h000000, 1, 1, 2, esp(24'h000002, 1, 0), "H_div1");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 24'h000000, 1, 1, 2, esp(24'h000002, 1, 0), "H_wait2");
      end
      applyStimulus(0, 0, 24'h000000, 1, 1, 2, esp(24'h000001, 1, 0), "H_div2");
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 24'h000000, 1, 1, 2, esp(24'h000001, 1, 0), "H_wait3");
      end
      applyStimulus(1, 0, 24'h000000, 1, 1, 2, esp(24'h000000, 0, 0), "H_midReset");
      applyStimulus(0, 0, 24'h000000, 1, 1, 2, esp(24'h000000, 0, 0), "H_afterReset");

      @(negedge clk);
      reset     = 1'b0;
      cargar    = 1'b0;
      habilitar = 1'b0;
      tick      = 1'b0;
      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/cuenta_regresiva_rtc.md
Name: cuenta_regresiva_rtc

Overview:
- Sequential, parametrised successor to the team's combinational time-subtraction block.
- Holds an hh:mm:ss value in packed BCD (one byte per field) and decrements it by one second on each tick, with full borrow propagation.
- Supports load, pause, zero detection, and either stop-at-zero or continuous wrap mode.
- Sits between the RTC register interface and the display/alarm logic; acts as a countdown timer.

Parameters:
- HORA_MAX, 8'h23, highest hour value in BCD; the hour field wraps to it and loads clamp to it.
- MODO_CONTINUO, 0, 0 = stop at 00:00:00; 1 = wrap to HORA_MAX:59:59 and keep counting.
- DIV_TICK, 0, 0 = use the external tick input; N>0 = internal prescaler issues one tick every N clk cycles while running, and the tick input is ignored.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cargar  input  1  load strobe; latches hora_in, minuto_in and segundo_in.
- hora_in  input  8  BCD hours to load.
- minuto_in  input  8  BCD minutes to load.
- segundo_in  input  8  BCD seconds to load.
- habilitar  input  1  level signal; 1 = count, 0 = pause.
- tick  input  1  one-cycle 1 Hz strobe; used only when DIV_TICK=0.
- hora_out  output  8  current BCD hours, registered.
- minuto_out  output  8  current BCD minutes, registered.
- segundo_out  output  8  current BCD seconds, registered.
- activo  output  1  high while in state RUN.
- fin  output  1  one-cycle pulse when the count reaches 00:00:00.

Behaviour:
- Reset (synchronous, active-high):
  - hora_out, minuto_out and segundo_out = 8'h00.
  - activo = 0, fin = 0, prescaler = 0, state = IDLE.
  - Reset asserted mid-run gives all-zero state at the next edge; any pending tick is discarded.
- States:
  - IDLE: value is held.
  - RUN: decrements on each effective tick.
  - DONE: value is held at zero; only reached when MODO_CONTINUO=0.
- State transitions:
  - IDLE -> RUN when habilitar=1 and the value is nonzero, or when MODO_CONTINUO=1.
  - RUN -> IDLE when habilitar=0; the value is held and the prescaler is cleared.
  - RUN -> DONE when a tick takes the value to zero and MODO_CONTINUO=0.
  - DONE -> IDLE on cargar, or when habilitar=0.
  - IDLE with a zero value, habilitar=1 and MODO_CONTINUO=0: stays in IDLE and fin is not asserted.
- Load:
  - cargar has priority over tick and over the state transitions; a tick in the same cycle is dropped.
  - The next state is IDLE; it moves to RUN on the following edge if the IDLE->RUN conditions hold.
  - The prescaler clears on load.
- Load validation, applied per field:
  - A field with any nibble > 9 loads as its maximum: 8'h59 for minutes/seconds, HORA_MAX for hours.
  - A field whose value exceeds its maximum also loads as that maximum.
- Effective tick:
  - DIV_TICK=0: the tick input, sampled only in RUN.
  - DIV_TICK>0: prescaler terminal count, reached every DIV_TICK clk cycles spent in RUN.
- Latency: an effective tick at edge N is reflected on the outputs after edge N, i.e. visible in cycle N+1.
- Decrement rules (BCD only; binary subtraction is never used):
  - Seconds units: x0 -> (x-1)9.
  - Seconds 00 -> 59, with a borrow into minutes.
  - Minutes 00 -> 59, with a borrow into hours.
  - Hours 00 -> HORA_MAX: only reachable when MODO_CONTINUO=1, from 00:00:00.
- fin:
  - Registered; high for exactly one cycle, coincident with the outputs first showing 00:00:00 after a tick.
  - Not asserted on a load of zero.
  - In continuous mode, pulses each time zero is reached.
- activo equals (state == RUN).

Test Plan:
- Reset -> all outputs 00, activo=0, fin=0.
- Load 00:01:00, habilitar=1, one tick -> 00:00:59. Load 01:00:00 plus one tick -> 00:59:59. Load 00:00:10 plus one tick -> 00:00:09.
- Load 00:00:02, habilitar=1, MODO_CONTINUO=0, 3 ticks -> 00:00:01, then 00:00:00 with fin=1 for 1 cycle, then the third tick is ignored and the state stays DONE.
- MODO_CONTINUO=1, HORA_MAX=8'h23, load 00:00:01, 2 ticks -> 00:00:00 with fin pulse, then 23:59:59.
- Load 8'h2A:8'h7B:8'h61 -> 23:59:59 (clamped). cargar and tick in the same cycle -> loaded value, no decrement. habilitar=0 mid-run -> value held, activo=0.
- DIV_TICK=4, load 00:00:03, habilitar=1 -> decrements every 4 cycles while in RUN. Reset asserted mid-run -> 00:00:00 at the next edge.
